serial_subtractor: RTL

- Bit-serial N-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a registered borrow.
- Arithmetic inverse of the 1-bit full adder cell already in the datapath.
- Sits beside the adder in the ALU datapath; start/busy/done handshake toward the controller.

---
 rtl/sub_pkg.sv | 15 +
 rtl/fullsub.sv | 24 ++
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit count of a counter that has to reach w without wrapping.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $unsigned($clog2(w + 1));
    endfunction

endpackage

// File: rtl/fullsub.sv
// Gate-level 1-bit full subtractor: d = x - y - bi, with borrow-out bo.
module fullsub (
    input  wire x,
    input  wire y,
    input  wire bi,
    output wire d,
    output wire bo
);

    wire xy_c;
    wire nx_c;
    wire nxy_c;
    wire t1_c;
    wire t2_c;

    xor g_xy  (xy_c, x, y);
    xor g_d   (d, xy_c, bi);
    not g_nx  (nx_c, x);
    and g_t1  (t1_c, nx_c, y);
    not g_nxy (nxy_c, xy_c);
    and g_t2  (t2_c, nxy_c, bi);
    or  g_bo  (bo, t1_c, t2_c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             brw_q, brw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             d_c;
    logic             bo_c;
    logic [WIDTH-1:0] r_next_c;

    fullsub u_cell (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .bi (brw_q),
        .d  (d_c),
        .bo (bo_c)
    );

    // New result bit enters at the MSB so the LSB-first stream lands in place.
    assign r_next_c = (r_sh_q >> 1) | (WIDTH'(d_c) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        brw_d   = brw_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = r_next_c;
                brw_d  = bo_c;
                // Results are loaded on the edge into DONE so they are valid with done.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = r_next_c;
                    bout_d  = bo_c;
                    ovf_d   = (a_msb_q != b_msb_q) && (d_c != a_msb_q);
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            brw_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            brw_q   <= brw_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
